// File: rtl/pmem_burst_pkg.sv
// Shared types and constants for the cacheline-to-burst adaptor.
package pmem_burst_pkg;

    localparam int LINE_W_DEF = 256;
    localparam int BEAT_W_DEF = 64;
    localparam int ADDR_W_DEF = 32;
    localparam int BEATS      = LINE_W_DEF / BEAT_W_DEF;
    localparam int BEAT_IDX_W = $clog2(BEATS);

    typedef logic [LINE_W_DEF-1:0] line_t;
    typedef logic [BEAT_W_DEF-1:0] beat_t;

    typedef enum logic [3:0] {
        IDLE     = 4'b0001,
        RD_BURST = 4'b0010,
        WR_BURST = 4'b0100,
        DONE     = 4'b1000
    } burst_state_t;

endpackage

// File: rtl/line_beat_buffer.sv
// Cacheline holding register: whole-line load for writes, beat-indexed fill for reads,
// beat-indexed drain mux for writes. Data only, so no reset.
module line_beat_buffer
    import pmem_burst_pkg::*;
#(
    parameter int LINE_W = LINE_W_DEF,
    parameter int BEAT_W = BEAT_W_DEF,
    parameter int IDX_W  = $clog2(LINE_W / BEAT_W)
) (
    input  logic              clk,
    input  logic              load_en,
    input  logic [LINE_W-1:0] load_line,
    input  logic              beat_we,
    input  logic [IDX_W-1:0]  beat_idx,
    input  logic [BEAT_W-1:0] beat_wdata,
    output logic [LINE_W-1:0] fill_line_o,
    output logic [BEAT_W-1:0] beat_rdata_o
);

    logic [LINE_W-1:0] line_q;

    // fill_line_o already contains the beat being written this cycle, so the
    // final read beat can be forwarded into the line output without an extra cycle.
    always_comb begin
        fill_line_o = line_q;
        if (beat_we) begin
            fill_line_o[beat_idx*BEAT_W +: BEAT_W] = beat_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (load_en) begin
            line_q <= load_line;
        end else if (beat_we) begin
            line_q <= fill_line_o;
        end
    end

    assign beat_rdata_o = line_q[beat_idx*BEAT_W +: BEAT_W];

endmodule

// File: rtl/pmem_burst_adaptor.sv
// Converts one L2 cacheline request into a 4-beat memory burst and returns a one-cycle line response.
// Optional perf counters enabled by defining PMEM_BURST_PERF_EN.
module pmem_burst_adaptor
    import pmem_burst_pkg::*;
#(
    parameter int LINE_W     = LINE_W_DEF,
    parameter int BEAT_W     = BEAT_W_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int PERF_CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              line_read_i,
    input  logic              line_write_i,
    input  logic [ADDR_W-1:0] line_addr_i,
    input  logic [LINE_W-1:0] line_wdata_i,
    output logic [LINE_W-1:0] line_rdata_o,
    output logic              line_resp_o,
    output logic              burst_read_o,
    output logic              burst_write_o,
    output logic [ADDR_W-1:0] burst_addr_o,
    output logic [BEAT_W-1:0] burst_wdata_o,
`ifdef PMEM_BURST_PERF_EN
    output logic [PERF_CNT_W-1:0] perf_rd_cnt_o,
    output logic [PERF_CNT_W-1:0] perf_wr_cnt_o,
    output logic [PERF_CNT_W-1:0] perf_stall_cnt_o,
`endif
    input  logic [BEAT_W-1:0] burst_rdata_i,
    input  logic              burst_resp_i
);

    localparam int NBEATS = LINE_W / BEAT_W;
    localparam int IDX_W  = $clog2(NBEATS);
    localparam int OFFS_W = $clog2(LINE_W / 8);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBEATS - 1);

    burst_state_t      state;
    logic [IDX_W-1:0]  beat_cnt;
    logic              last_beat;
    logic              buf_load;
    logic              buf_beat_we;
    logic [LINE_W-1:0] buf_fill_line;
    logic [BEAT_W-1:0] buf_beat_rdata;
    logic              unused_addr_lo;

    assign unused_addr_lo = ^line_addr_i[OFFS_W-1:0];
    assign last_beat      = (beat_cnt == LAST_IDX);
    assign buf_load       = (state == IDLE) && line_write_i;
    assign buf_beat_we    = (state == RD_BURST) && burst_resp_i;

    line_beat_buffer #(
        .LINE_W (LINE_W),
        .BEAT_W (BEAT_W),
        .IDX_W  (IDX_W)
    ) u_line_buf (
        .clk          (clk),
        .load_en      (buf_load),
        .load_line    (line_wdata_i),
        .beat_we      (buf_beat_we),
        .beat_idx     (beat_cnt),
        .beat_wdata   (burst_rdata_i),
        .fill_line_o  (buf_fill_line),
        .beat_rdata_o (buf_beat_rdata)
    );

    // The line buffer is not reset, so the drain path is gated to keep the port at 0 outside writes.
    assign burst_wdata_o = burst_write_o ? buf_beat_rdata : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            beat_cnt      <= '0;
            line_rdata_o  <= '0;
            line_resp_o   <= 1'b0;
            burst_read_o  <= 1'b0;
            burst_write_o <= 1'b0;
            burst_addr_o  <= '0;
        end else begin
            line_resp_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (line_write_i) begin
                        state         <= WR_BURST;
                        burst_write_o <= 1'b1;
                        burst_addr_o  <= {line_addr_i[ADDR_W-1:OFFS_W], OFFS_W'(0)};
                    end else if (line_read_i) begin
                        state        <= RD_BURST;
                        burst_read_o <= 1'b1;
                        burst_addr_o <= {line_addr_i[ADDR_W-1:OFFS_W], OFFS_W'(0)};
                    end
                end
                RD_BURST: begin
                    if (burst_resp_i) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (last_beat) begin
                            state        <= DONE;
                            burst_read_o <= 1'b0;
                            line_resp_o  <= 1'b1;
                            line_rdata_o <= buf_fill_line;
                        end
                    end
                end
                WR_BURST: begin
                    if (burst_resp_i) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (last_beat) begin
                            state         <= DONE;
                            burst_write_o <= 1'b0;
                            line_resp_o   <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    // The L2 still holds its request here; it is deliberately not sampled.
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef PMEM_BURST_PERF_EN
    function automatic logic [PERF_CNT_W-1:0] sat_inc(input logic [PERF_CNT_W-1:0] cnt);
        return (&cnt) ? cnt : cnt + 1'b1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_rd_cnt_o    <= '0;
            perf_wr_cnt_o    <= '0;
            perf_stall_cnt_o <= '0;
        end else begin
            if (state == RD_BURST && burst_resp_i && last_beat) begin
                perf_rd_cnt_o <= sat_inc(perf_rd_cnt_o);
            end
            if (state == WR_BURST && burst_resp_i && last_beat) begin
                perf_wr_cnt_o <= sat_inc(perf_wr_cnt_o);
            end
            if ((state == RD_BURST || state == WR_BURST) && !burst_resp_i) begin
                perf_stall_cnt_o <= sat_inc(perf_stall_cnt_o);
            end
        end
    end
`else
    localparam int unused_perf_cnt_w = PERF_CNT_W;
`endif

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(state == IDLE && line_read_i && line_write_i))
                else $warning("pmem_burst_adaptor: read and write requested together, write taken");
            assert (!(burst_resp_i && state != RD_BURST && state != WR_BURST))
                else $warning("pmem_burst_adaptor: burst_resp_i outside a burst ignored");
        end
    end
`endif

endmodule
